frame_deserializer: RTL and testbench
=====================================

Name: frame_deserializer

Overview:
Generalised successor to the round-robin task deserializer. It collects one framed serial stream (first/last delimited) into up to MAX_STREAMS lane buffers, one beat per lane, round-robin. Once the frame ends, it replays the buffers as parallel rows under a valid/ready handshake. Adds runtime lane count, input backpressure, partial-row padding, overflow/truncation reporting and output flow control. Sits between the UART RX framer and the parallel task datapath.

Parameters:
DATA_WIDTH, 8, bits per beat/lane
MAX_STREAMS, 4, number of physical lanes (>=2)
DEPTH, 256, rows per lane buffer (power of 2)
PAD_VALUE, 0, value written into unfilled lanes of the final row

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_num_streams  in  $clog2(MAX_STREAMS)+1  active lane count, sampled on frame start
i_data  in  DATA_WIDTH  input beat
i_valid  in  1  input beat valid
i_first  in  1  first beat of frame
i_last  in  1  last beat of frame
o_ready  out  1  input ready
o_data  out  DATA_WIDTH x MAX_STREAMS  unpacked array, one row
o_valid  out  1  row valid
i_ready  in  1  downstream ready
o_first  out  1  first row of frame (qualified by o_valid)
o_last  out  1  last row of frame
o_pad_mask  out  MAX_STREAMS  lanes holding PAD_VALUE in the current row
o_trunc  out  1  frame lost beats to overflow (valid with o_last)

Behaviour:
- Reset: one clock i_clk, synchronous active-high reset i_rst. All outputs are 0 during and after reset, except o_ready=1. State=IDLE, pointers cleared. Reset mid-frame or mid-send discards all buffered data.
- Accept: a beat is accepted when i_valid & o_ready. o_ready=1 in IDLE/LOAD, 0 in PAD/SEND.
- IDLE:
  - Accepted beat with i_first: latch cfg_n = i_num_streams (0 or >MAX_STREAMS -> MAX_STREAMS), write to lane 0 row 0, lane_ptr=1, go LOAD.
  - If that beat also has i_last: go PAD (cfg_n>1) or SEND (cfg_n=1).
  - Accepted beats without i_first are discarded.
- LOAD:
  - Each accepted beat is written to lane lane_ptr at row wr_row. lane_ptr increments; on reaching cfg_n-1 it wraps to 0 and wr_row increments.
  - i_first mid-frame is treated as ordinary data.
  - On accepted i_last: go SEND if the post-write lane_ptr=0, else PAD.
- Overflow: a write when wr_row==DEPTH drops the beat and sets the sticky trunc flag. The frame continues until i_last, and no write overflows a lane.
- PAD: writes PAD_VALUE to lane_ptr..cfg_n-1 of the final row, one lane per cycle, and sets the matching pad_mask bits. Then go SEND with wr_row incremented. Skip PAD when trunc is set and wr_row==DEPTH.
- SEND:
  - o_valid=1 from the first SEND cycle (one cycle after the last write) while rd_row<wr_row.
  - A row transfers on o_valid & i_ready, then rd_row increments. o_data/o_first/o_last hold stable while i_ready=0.
  - o_first=1 when rd_row==0. o_last=1 when rd_row==wr_row-1; o_pad_mask and o_trunc are nonzero only on that row.
  - Lanes >= cfg_n output 0.
  - After the o_last transfer: go IDLE, clear all pointers and flags.
- Widths: wr_row/rd_row are $clog2(DEPTH+1) bits. lane_ptr is $clog2(MAX_STREAMS) bits.
- Empty frame is impossible: every frame has at least 1 row.

Optional Feature:
Macro FRAME_DESERIALIZER_STATS_EN.
- Defined: adds outputs o_frame_cnt (16b, frames completed, wraps), o_drop_cnt (16b, beats dropped in IDLE or to overflow, saturating) and o_err (1-cycle pulse on each dropped beat). All counters are cleared by i_rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package frame_deserializer_pkg: state enum (IDLE, LOAD, PAD, SEND) and the clamp function for i_num_streams.
- Sub-module deser_lane_ram: one per lane; simple dual-port, distributed, DEPTH x DATA_WIDTH, synchronous write, asynchronous read by rd_row.
- Row pointers are shared in the parent; no per-lane FIFOs.

Test Plan:
1. N=3, 6-beat frame 0x10..0x15, i_ready=1 -> 2 rows {10,11,12},{13,14,15}; o_first on row 0, o_last on row 1, pad_mask=0.
2. N=4, 5-beat frame 0xA0..0xA4 -> rows {A0..A3},{A4,0,0,0}; last row pad_mask=4'b1110; o_ready=0 for the 3 PAD cycles.
3. Toggle i_ready 1/0 every cycle during SEND -> each row is held stable until transferred; no row is lost or duplicated.
4. DEPTH=4, N=2, 11-beat frame -> 4 rows with beats 0..7 only; o_trunc=1 with o_last; beats 8..10 dropped.
5. Single-beat frame with i_first & i_last, N=1 -> one row, o_first=o_last=1, next cycle IDLE.
6. Assert i_rst mid-LOAD, then send a new 4-beat frame with N=2 -> only the new frame's 2 rows appear; o_valid=0 and o_ready=1 right after reset.

Source files
------------

// File: rtl/frame_deserializer_pkg.sv
// Shared types and helpers for the frame deserializer.
// Holds the FSM state enum and the lane-count clamp function.
package frame_deserializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PAD,
        SEND
    } state_t;

    // Out-of-range lane counts fall back to every physical lane.
    function automatic int clamp_streams(input int n, input int max_n);
        return (n == 0 || n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/deser_lane_ram.sv
// One lane buffer: DEPTH x DATA_WIDTH simple dual-port distributed RAM.
// Ports: i_clk, i_we/i_waddr/i_wdata (sync write), i_raddr/o_rdata (async read).
module deser_lane_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/frame_deserializer.sv
// Collects a first/last framed beat stream round-robin into lane buffers,
// then replays them as parallel rows under a valid/ready handshake.
// Ports: i_clk, i_rst (sync, active high), i_num_streams (lanes, sampled on
// frame start), input beat i_data/i_valid/i_first/i_last with o_ready,
// output row o_data[]/o_valid/o_first/o_last/o_pad_mask/o_trunc with i_ready.
// Optional macro FRAME_DESERIALIZER_STATS_EN adds o_frame_cnt, o_drop_cnt, o_err.
module frame_deserializer
    import frame_deserializer_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    MAX_STREAMS = 4,
    parameter int                    DEPTH       = 256,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '0
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [$clog2(MAX_STREAMS):0]     i_num_streams,
    input  logic [DATA_WIDTH-1:0]            i_data,
    input  logic                             i_valid,
    input  logic                             i_first,
    input  logic                             i_last,
    output logic                             o_ready,
    output logic [DATA_WIDTH-1:0]            o_data [MAX_STREAMS],
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_first,
    output logic                             o_last,
    output logic [MAX_STREAMS-1:0]           o_pad_mask,
    output logic                             o_trunc
`ifdef FRAME_DESERIALIZER_STATS_EN
    ,
    output logic [15:0]                      o_frame_cnt,
    output logic [15:0]                      o_drop_cnt,
    output logic                             o_err
`endif
);

    localparam int CW = $clog2(MAX_STREAMS) + 1;
    localparam int LW = $clog2(MAX_STREAMS);
    localparam int RW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    state_t                  state, state_n;
    logic [CW-1:0]           cfg_n, cfg_in, cur_n;
    logic [LW-1:0]           lane_ptr;
    logic [RW-1:0]           wr_row, rd_row;
    logic                    trunc;
    logic [MAX_STREAMS-1:0]  pad_mask;
    logic [DATA_WIDTH-1:0]   rdata [MAX_STREAMS];

    logic accept, start, load_wr, full, lane_wrap;
    logic do_write, pad_wr, wr_en, xfer, last_row;
    logic [DATA_WIDTH-1:0] wdata;

    assign cfg_in = CW'(clamp_streams(int'(i_num_streams), MAX_STREAMS));
    // In IDLE the frame's lane count is not latched yet, so use the live one.
    assign cur_n     = (state == IDLE) ? cfg_in : cfg_n;
    assign lane_wrap = ({1'b0, lane_ptr} == cur_n - CW'(1));
    assign full      = (wr_row == RW'(DEPTH));
    assign accept    = i_valid & o_ready;
    assign start     = (state == IDLE) & accept & i_first;
    assign load_wr   = (state == LOAD) & accept;
    assign do_write  = start | (load_wr & ~full);
    assign pad_wr    = (state == PAD);
    assign wr_en     = do_write | pad_wr;
    assign wdata     = pad_wr ? PAD_VALUE : i_data;
    assign o_valid   = (state == SEND) & (rd_row < wr_row);
    assign xfer      = o_valid & i_ready;
    assign last_row  = (rd_row == wr_row - RW'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        o_ready = 1'b0;
        unique case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (start) begin
                    if (!i_last) state_n = LOAD;
                    else         state_n = lane_wrap ? SEND : PAD;
                end
            end
            LOAD: begin
                o_ready = 1'b1;
                // A full buffer only occurs right after a row wrap, so the
                // final row is already complete and padding is skipped.
                if (accept && i_last) begin
                    state_n = (full || lane_wrap) ? SEND : PAD;
                end
            end
            PAD: begin
                if (lane_wrap) state_n = SEND;
            end
            SEND: begin
                if (xfer && last_row) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cfg_n    <= '0;
            lane_ptr <= '0;
            wr_row   <= '0;
            rd_row   <= '0;
            trunc    <= 1'b0;
            pad_mask <= '0;
        end else begin
            if (start) begin
                cfg_n <= cfg_in;
            end
            if (wr_en) begin
                if (lane_wrap) begin
                    lane_ptr <= '0;
                    wr_row   <= wr_row + RW'(1);
                end else begin
                    lane_ptr <= lane_ptr + LW'(1);
                end
            end
            if (pad_wr) begin
                pad_mask[lane_ptr] <= 1'b1;
            end
            if (load_wr && full) begin
                trunc <= 1'b1;
            end
            if (xfer) begin
                if (last_row) begin
                    lane_ptr <= '0;
                    wr_row   <= '0;
                    rd_row   <= '0;
                    trunc    <= 1'b0;
                    pad_mask <= '0;
                end else begin
                    rd_row <= rd_row + RW'(1);
                end
            end
        end
    end

    for (genvar l = 0; l < MAX_STREAMS; l++) begin : g_lane
        deser_lane_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_ram (
            .i_clk  (i_clk),
            .i_we   (wr_en && (lane_ptr == LW'(l))),
            .i_waddr(wr_row[AW-1:0]),
            .i_wdata(wdata),
            .i_raddr(rd_row[AW-1:0]),
            .o_rdata(rdata[l])
        );
        assign o_data[l] = (o_valid && (CW'(l) < cfg_n)) ? rdata[l] : '0;
    end

    assign o_first    = o_valid & (rd_row == '0);
    assign o_last     = o_valid & last_row;
    assign o_pad_mask = o_last ? pad_mask : '0;
    assign o_trunc    = o_last & trunc;

`ifdef FRAME_DESERIALIZER_STATS_EN
    logic drop;

    assign drop = ((state == IDLE) & accept & ~i_first) | (load_wr & full);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_cnt <= '0;
            o_drop_cnt  <= '0;
            o_err       <= 1'b0;
        end else begin
            o_err <= drop;
            if (xfer && last_row) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if (drop && o_drop_cnt != 16'hFFFF) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer: directed frames plus random
// frames, checked against a row model derived from the framing rules.
module tb_frame_deserializer;

    localparam int DW   = 8;
    localparam int MS   = 4;
    localparam int DP   = 4;
    localparam logic [DW-1:0] PADV = 8'h00;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    num;
    logic [DW-1:0] din;
    logic          vin, first, last, rdy_o;
    logic [DW-1:0] dout [MS];
    logic          vout, rdy_in, fo, lo, tr;
    logic [MS-1:0] pm;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] frame [$];

    always #5 clk = ~clk;

    frame_deserializer #(
        .DATA_WIDTH (DW),
        .MAX_STREAMS(MS),
        .DEPTH      (DP),
        .PAD_VALUE  (PADV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_num_streams(num),
        .i_data       (din),
        .i_valid      (vin),
        .i_first      (first),
        .i_last       (last),
        .o_ready      (rdy_o),
        .o_data       (dout),
        .o_valid      (vout),
        .i_ready      (rdy_in),
        .o_first      (fo),
        .o_last       (lo),
        .o_pad_mask   (pm),
        .o_trunc      (tr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives the beats in `frame`, then collects and checks every row.
    task automatic run_frame(input int n_raw, input int rmode, input int gap,
                             input int junk, input bit midf, input string tag);
        int cfg, len, cap, kept, rows, padc, idx, cyc, r, pads, k;
        bit trn, tog;
        logic [DW-1:0] ev;
        logic [MS-1:0] em;

        cfg  = (n_raw == 0 || n_raw > MS) ? MS : n_raw;
        len  = frame.size();
        cap  = DP * cfg;
        kept = (len < cap) ? len : cap;
        trn  = (len > cap);
        rows = (kept + cfg - 1) / cfg;
        padc = (kept % cfg != 0) ? cfg - (kept % cfg) : 0;

        num    = 3'(n_raw);
        rdy_in = 1'b0;
        for (int j = 0; j < junk; j++) begin
            @(negedge clk);
            vin = 1'b1; first = 1'b0; last = 1'b0; din = 8'($urandom);
        end

        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_ready_load"}, rdy_o, 1);
            vin   = ($urandom_range(99) >= gap);
            din   = frame[idx];
            first = (idx == 0) || (midf && $urandom_range(3) == 0);
            last  = (idx == len - 1);
            if (vin && rdy_o) idx++;
        end
        check({tag, "_beats_taken"}, idx, len);
        @(negedge clk);
        vin = 1'b0; first = 1'b0; last = 1'b0;
        check({tag, "_ready_busy"}, rdy_o, 0);

        r    = 0;
        pads = 0;
        cyc  = 0;
        tog  = 1'b0;
        while (r < rows && cyc < 400) begin
            if (vout) begin
                em = '0;
                for (int l = 0; l < MS; l++) begin
                    k = r * cfg + l;
                    if (l >= cfg) ev = '0;
                    else if (k < kept) ev = frame[k];
                    else begin
                        ev = PADV;
                        em[l] = 1'b1;
                    end
                    check($sformatf("%s_r%0d_l%0d", tag, r, l), dout[l], ev);
                end
                check($sformatf("%s_r%0d_first", tag, r), fo, r == 0);
                check($sformatf("%s_r%0d_last", tag, r), lo, r == rows - 1);
                check($sformatf("%s_r%0d_mask", tag, r), pm,
                      (r == rows - 1) ? em : '0);
                check($sformatf("%s_r%0d_trunc", tag, r), tr,
                      trn && (r == rows - 1));
            end else if (r == 0) begin
                pads++;
            end else begin
                check({tag, "_valid_gap"}, vout, 1);
            end
            tog = ~tog;
            if (rmode == 0)      rdy_in = 1'b1;
            else if (rmode == 1) rdy_in = tog;
            else                 rdy_in = ($urandom_range(1) == 1);
            if (vout && rdy_in) r++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_rows"}, r, rows);
        check({tag, "_pad_cycles"}, pads, padc);
        check({tag, "_idle_valid"}, vout, 0);
        check({tag, "_idle_ready"}, rdy_o, 1);
        rdy_in = 1'b0;
    endtask

    initial begin
        int n, c, len;
        rst = 1'b1; num = '0; din = '0; vin = 1'b0;
        first = 1'b0; last = 1'b0; rdy_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", rdy_o, 1);
        check("rst_valid", vout, 0);
        check("rst_first", fo, 0);
        check("rst_last", lo, 0);
        check("rst_mask", pm, 0);
        check("rst_trunc", tr, 0);
        check("rst_data0", dout[0], 0);
        rst = 1'b0;

        frame.delete();
        for (int i = 0; i < 6; i++) frame.push_back(8'(8'h10 + i));
        run_frame(3, 0, 0, 0, 0, "t1");

        frame.delete();
        for (int i = 0; i < 5; i++) frame.push_back(8'(8'hA0 + i));
        run_frame(4, 0, 0, 0, 0, "t2");

        frame.delete();
        for (int i = 0; i < 7; i++) frame.push_back(8'(8'h30 + i));
        run_frame(2, 1, 0, 0, 0, "t3");

        frame.delete();
        for (int i = 0; i < 11; i++) frame.push_back(8'(i));
        run_frame(2, 0, 0, 0, 0, "t4");

        frame.delete();
        frame.push_back(8'h5A);
        run_frame(1, 0, 0, 0, 0, "t5");

        @(negedge clk);
        num = 3'd2; vin = 1'b1; first = 1'b1; last = 1'b0; din = 8'h55;
        @(negedge clk);
        first = 1'b0; din = 8'h56;
        @(negedge clk);
        din = 8'h57;
        @(negedge clk);
        vin = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", vout, 0);
        check("t6_rst_ready", rdy_o, 1);
        rst = 1'b0;
        frame.delete();
        for (int i = 0; i < 4; i++) frame.push_back(8'(8'hC0 + i));
        run_frame(2, 0, 0, 0, 0, "t6");

        frame.delete();
        for (int i = 0; i < 3; i++) frame.push_back(8'(8'hE0 + i));
        run_frame(0, 0, 0, 2, 0, "junk_n0");

        for (int it = 0; it < 24; it++) begin
            n   = $urandom_range(7);
            c   = (n == 0 || n > MS) ? MS : n;
            len = $urandom_range(DP * c + 3, 1);
            frame.delete();
            for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
            run_frame(n, $urandom_range(2), 30, $urandom_range(2), 1,
                      $sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
